// File: rtl/ppu_layer_mixer.sv
// ============================================================================
// ppu_layer_mixer
// ----------------------------------------------------------------------------
// Purpose:
//   N-layer priority compositor for the PPU. Every pixel clock it takes one
//   colour per sprite/tile layer and outputs the colour of the lowest-index
//   layer that is both enabled and not equal to the transparent colour key.
//   If no layer qualifies, it outputs a programmable background colour.
//
//   The layer enable mask and background colour are written over Avalon into
//   shadow registers. The shadow values are copied into the active registers
//   once per frame, at a programmable raster point, so a frame never shows a
//   half-updated configuration. The IMMEDIATE control bit bypasses this and
//   updates the active copy on the same edge as the write.
//
//   The datapath is a 2-stage pipeline. The raster counters travel alongside
//   it, so hcount_out/vcount_out always describe the pixel on RGB_output.
//
// Ports:
//   clk         in   pixel/system clock
//   reset       in   synchronous, active-low reset (0 = in reset)
//   chipselect  in   Avalon select
//   write       in   Avalon write strobe (needs chipselect as well)
//   address     in   [2:0]  register index: 0 EN_MASK, 1 BG_COLOR, 2 CTRL
//   writedata   in   [31:0] register data
//   hcount      in   [9:0]  raster column of layer_rgb this cycle
//   vcount      in   [9:0]  raster row of layer_rgb this cycle
//   layer_rgb   in   [NUM_LAYERS*COLOR_W-1:0] layer i at [i*COLOR_W +: COLOR_W]
//   RGB_output  out  [COLOR_W-1:0] composited pixel
//   layer_hit   out  [$clog2(NUM_LAYERS)-1:0] winning layer (0 on background)
//   hit_valid   out  1 = a layer won, 0 = background shown
//   hcount_out  out  [9:0] hcount delayed 2 cycles
//   vcount_out  out  [9:0] vcount delayed 2 cycles
// ============================================================================
module ppu_layer_mixer #(
    parameter int                 NUM_LAYERS  = 20,
    parameter int                 COLOR_W     = 24,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 24'h202020,
    parameter logic [9:0]         H_COMMIT    = 10'd0,
    parameter logic [9:0]         V_COMMIT    = 10'd480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [2:0]                    address,
    input  logic [31:0]                   writedata,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    output logic [COLOR_W-1:0]            RGB_output,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_hit,
    output logic                          hit_valid,
    output logic [9:0]                    hcount_out,
    output logic [9:0]                    vcount_out
);

    localparam int HIT_W = $clog2(NUM_LAYERS);

    // ------------------------------------------------------------------------
    // Register-file decode
    // ------------------------------------------------------------------------
    logic w_write;
    logic w_wrMask;
    logic w_wrBg;
    logic w_wrCtrl;
    logic w_commit;

    assign w_write  = chipselect & write;
    assign w_wrMask = w_write & (address == 3'd0);
    assign w_wrBg   = w_write & (address == 3'd1);
    assign w_wrCtrl = w_write & (address == 3'd2);

    // Once-per-frame raster point at which shadow copies become active.
    assign w_commit = (hcount == H_COMMIT) && (vcount == V_COMMIT);

    // ------------------------------------------------------------------------
    // Configuration state
    // ------------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] r_shadowMask;
    logic [NUM_LAYERS-1:0] r_activeMask;
    logic [COLOR_W-1:0]    r_shadowBg;
    logic [COLOR_W-1:0]    r_activeBg;
    logic                  r_immediate;
    logic                  r_blank;

    // CTRL is not shadowed: a write here changes behaviour from the next edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_immediate <= 1'b0;
            r_blank     <= 1'b0;
        end else if (w_wrCtrl) begin
            r_immediate <= writedata[0];
            r_blank     <= writedata[1];
        end
    end

    // Layer enable mask. The shadow always takes a write. The active copy
    // takes the written value directly in IMMEDIATE mode; otherwise it loads
    // the shadow at the commit point. On a commit edge that also carries a
    // normal write, the active copy picks up the shadow value from before the
    // write, and the new value waits for the next frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadowMask <= '1;
            r_activeMask <= '1;
        end else begin
            if (w_wrMask) begin
                r_shadowMask <= writedata[NUM_LAYERS-1:0];
            end
            if (w_wrMask && r_immediate) begin
                r_activeMask <= writedata[NUM_LAYERS-1:0];
            end else if (w_commit) begin
                r_activeMask <= r_shadowMask;
            end
        end
    end

    // Background colour. The shadow/active handling matches the mask above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadowBg <= TRANSPARENT;
            r_activeBg <= TRANSPARENT;
        end else begin
            if (w_wrBg) begin
                r_shadowBg <= writedata[COLOR_W-1:0];
            end
            if (w_wrBg && r_immediate) begin
                r_activeBg <= writedata[COLOR_W-1:0];
            end else if (w_commit) begin
                r_activeBg <= r_shadowBg;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: per-layer opacity qualification
    // ------------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] w_opaque;

    // A layer competes only if it is enabled in the active mask and is not
    // showing the colour key.
    always_comb begin
        w_opaque = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_opaque[i] = r_activeMask[i] &
                          (layer_rgb[i*COLOR_W +: COLOR_W] != TRANSPARENT);
        end
    end

    logic [NUM_LAYERS*COLOR_W-1:0] r_s1Colors;
    logic [NUM_LAYERS-1:0]         r_s1Opaque;
    logic [9:0]                    r_s1H;
    logic [9:0]                    r_s1V;
    logic                          r_s1Blank;

    // Stage 1 registers the opacity vector along with the raw colours, the
    // raster position and the BLANK flag, so all of them stay with the pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1Colors <= '0;
            r_s1Opaque <= '0;
            r_s1H      <= '0;
            r_s1V      <= '0;
            r_s1Blank  <= 1'b0;
        end else begin
            r_s1Colors <= layer_rgb;
            r_s1Opaque <= w_opaque;
            r_s1H      <= hcount;
            r_s1V      <= vcount;
            r_s1Blank  <= r_blank;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: priority selection
    // ------------------------------------------------------------------------
    logic [HIT_W-1:0]   w_win;
    logic               w_anyOpaque;
    logic [COLOR_W-1:0] w_winColor;

    // Priority encoder. The loop scans from the highest index down, and each
    // opaque layer overwrites the previous candidate. The last write, from the
    // lowest opaque index, therefore wins. The colour is picked inside the
    // same loop, which keeps the part-select index inside the layer range.
    always_comb begin
        w_win       = '0;
        w_anyOpaque = 1'b0;
        w_winColor  = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_s1Opaque[i]) begin
                w_win       = HIT_W'(i);
                w_anyOpaque = 1'b1;
                w_winColor  = r_s1Colors[i*COLOR_W +: COLOR_W];
            end
        end
    end

    logic [COLOR_W-1:0] r_rgbOut;
    logic [HIT_W-1:0]   r_hitOut;
    logic               r_hitValid;
    logic [9:0]         r_hOut;
    logic [9:0]         r_vOut;

    // Output register. The background colour is taken from the active
    // register at this edge rather than carried through stage 1. A commit
    // therefore changes the background on the very next output pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rgbOut   <= '0;
            r_hitOut   <= '0;
            r_hitValid <= 1'b0;
            r_hOut     <= '0;
            r_vOut     <= '0;
        end else begin
            r_hOut <= r_s1H;
            r_vOut <= r_s1V;
            if (r_s1Blank || !w_anyOpaque) begin
                r_rgbOut   <= r_activeBg;
                r_hitOut   <= '0;
                r_hitValid <= 1'b0;
            end else begin
                r_rgbOut   <= w_winColor;
                r_hitOut   <= w_win;
                r_hitValid <= 1'b1;
            end
        end
    end

    assign RGB_output = r_rgbOut;
    assign layer_hit  = r_hitOut;
    assign hit_valid  = r_hitValid;
    assign hcount_out = r_hOut;
    assign vcount_out = r_vOut;

endmodule
